// File: rtl/stp16_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : stp16_frame_scheduler
// Brief    : Arbitrates meter/overlay frames into one STP16CPC26 driver with
//            coalescing, minimum update gap, overlay hold and periodic refresh.
// Revision : 1.0 - initial release
// ============================================================================
module stp16_frame_scheduler #(
    parameter int WIDTH          = 32,
    parameter int MIN_INTERVAL   = 1024,
    parameter int REFRESH_PERIOD = 65536,
    parameter int OVERLAY_HOLD   = 262144
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s0_valid,
    input  logic [WIDTH-1:0] s0_data,
    output logic             s0_ready,
    input  logic             s1_valid,
    input  logic [WIDTH-1:0] s1_data,
    output logic             s1_ready,
    output logic             drv_valid,
    output logic [WIDTH-1:0] drv_data,
    input  logic             drv_ready,
    output logic             overlay_active,
    output logic             drop
);

    localparam int GAP_W  = (MIN_INTERVAL > 1) ? $clog2(MIN_INTERVAL) : 1;
    localparam int REF_W  = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    // Sized to hold the full reload value, which may be an exact power of two
    localparam int HOLD_W = (OVERLAY_HOLD > 0) ? $clog2(OVERLAY_HOLD + 1) : 1;

    localparam logic [GAP_W-1:0]  GAP_RELOAD  = GAP_W'(MIN_INTERVAL - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE     = GAP_W'(1);
    localparam logic [REF_W-1:0]  REF_RELOAD  = REF_W'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);
    localparam logic [REF_W-1:0]  REF_ONE     = REF_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(OVERLAY_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              s0_ready_q, s1_ready_q;
    logic              drv_valid_q, drv_valid_d;
    logic [WIDTH-1:0]  drv_data_q, drv_data_d;
    logic              overlay_active_q, overlay_active_d;
    logic              drop_q, drop_d;
    logic [WIDTH-1:0]  shadow_q, shadow_d;
    logic              dirty_q, dirty_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [REF_W-1:0]  refresh_cnt_q, refresh_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic s0_take, s1_take, s0_store, frame_store;
    logic refresh_due, issue_req, launch, handshake;

    always_comb begin : p_accept
        s1_take          = s1_valid & s1_ready_q;
        s0_take          = s0_valid & s0_ready_q;
        s0_store         = s0_take & ~s1_take & (hold_cnt_q == '0);
        frame_store      = s1_take | s0_store;
        drop_d           = s0_take & ~s0_store;
        shadow_d         = shadow_q;
        if (s1_take) begin
            shadow_d = s1_data;
        end else if (s0_store) begin
            shadow_d = s0_data;
        end
        hold_cnt_d       = hold_cnt_q;
        if (s1_take) begin
            hold_cnt_d = HOLD_RELOAD;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HOLD_ONE;
        end
        overlay_active_d = (hold_cnt_d != '0);
    end

    assign refresh_due = (REFRESH_PERIOD != 0) && (refresh_cnt_q == '0);
    assign issue_req   = (gap_cnt_q == '0) && (dirty_q || refresh_due);

    always_ff @(posedge clk) begin : p_state_reg
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The gap's final cycle may launch directly, so a handshake at T gives
    // the next drv_valid rise at T + MIN_INTERVAL + 1 at the earliest.
    always_comb begin : p_next_state
        state_d   = state_q;
        launch    = 1'b0;
        handshake = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue_req) begin
                    state_d = ST_ISSUE;
                    launch  = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (drv_valid_q && drv_ready) begin
                    state_d   = ST_GAP;
                    handshake = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    if (issue_req) begin
                        state_d = ST_ISSUE;
                        launch  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin : p_outputs
        drv_valid_d = (state_d == ST_ISSUE);
        drv_data_d  = launch ? shadow_q : drv_data_q;
    end

    // Dirty is cleared at launch, so any frame stored while the current one is
    // in flight (including the launch cycle itself) is sent after the gap.
    always_comb begin : p_counters
        dirty_d = launch ? frame_store : (dirty_q | frame_store);

        gap_cnt_d = gap_cnt_q;
        if (handshake) begin
            gap_cnt_d = GAP_RELOAD;
        end else if ((state_q == ST_GAP) && (gap_cnt_q != '0)) begin
            gap_cnt_d = gap_cnt_q - GAP_ONE;
        end

        refresh_cnt_d = refresh_cnt_q;
        if (handshake) begin
            refresh_cnt_d = REF_RELOAD;
        end else if ((state_q != ST_ISSUE) && (refresh_cnt_q != '0)) begin
            refresh_cnt_d = refresh_cnt_q - REF_ONE;
        end
    end

    always_ff @(posedge clk) begin : p_regs
        if (reset) begin
            s0_ready_q       <= 1'b0;
            s1_ready_q       <= 1'b0;
            drv_valid_q      <= 1'b0;
            drv_data_q       <= '0;
            overlay_active_q <= 1'b0;
            drop_q           <= 1'b0;
            shadow_q         <= '0;
            dirty_q          <= 1'b1;
            gap_cnt_q        <= '0;
            refresh_cnt_q    <= '0;
            hold_cnt_q       <= '0;
        end else begin
            s0_ready_q       <= 1'b1;
            s1_ready_q       <= 1'b1;
            drv_valid_q      <= drv_valid_d;
            drv_data_q       <= drv_data_d;
            overlay_active_q <= overlay_active_d;
            drop_q           <= drop_d;
            shadow_q         <= shadow_d;
            dirty_q          <= dirty_d;
            gap_cnt_q        <= gap_cnt_d;
            refresh_cnt_q    <= refresh_cnt_d;
            hold_cnt_q       <= hold_cnt_d;
        end
    end

    assign s0_ready       = s0_ready_q;
    assign s1_ready       = s1_ready_q;
    assign drv_valid      = drv_valid_q;
    assign drv_data       = drv_data_q;
    assign overlay_active = overlay_active_q;
    assign drop           = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_stp16_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_stp16_frame_scheduler
// Brief    : Directed + random bench for two scheduler configurations against
//            a timestamp-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stp16_frame_scheduler;

    localparam int W     = 32;
    localparam int HOLD  = 100;
    localparam int MI0   = 8;
    localparam int RP0   = 64;
    localparam int MI1   = 4;
    localparam int RP1   = 0;
    localparam int NEVER = -1000000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         s0_valid = 1'b0;
    logic         s1_valid = 1'b0;
    logic         drv_ready = 1'b0;
    logic [W-1:0] s0_data = '0;
    logic [W-1:0] s1_data = '0;
    logic [1:0]   s0_ready, s1_ready, drv_valid, overlay_active, drop;
    logic [W-1:0] drv_data [2];

    stp16_frame_scheduler #(
        .WIDTH(W), .MIN_INTERVAL(MI0), .REFRESH_PERIOD(RP0), .OVERLAY_HOLD(HOLD)
    ) u_dut0 (
        .clk(clk), .reset(reset),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready[0]),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready[0]),
        .drv_valid(drv_valid[0]), .drv_data(drv_data[0]), .drv_ready(drv_ready),
        .overlay_active(overlay_active[0]), .drop(drop[0])
    );

    stp16_frame_scheduler #(
        .WIDTH(W), .MIN_INTERVAL(MI1), .REFRESH_PERIOD(RP1), .OVERLAY_HOLD(HOLD)
    ) u_dut1 (
        .clk(clk), .reset(reset),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready[1]),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready[1]),
        .drv_valid(drv_valid[1]), .drv_data(drv_data[1]), .drv_ready(drv_ready),
        .overlay_active(overlay_active[1]), .drop(drop[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc;

    // Reference model: shared source-side state plus per-instance issue timing
    bit           m_ready;
    logic [W-1:0] m_shadow;
    int           m_last_store, m_last_s1;
    bit           m_drop;
    bit           m_valid [2];
    logic [W-1:0] m_data [2];
    int           m_last_hs [2];
    int           m_last_latch [2];

    function automatic int mi_of(int i);
        return (i == 0) ? MI0 : MI1;
    endfunction

    function automatic int rp_of(int i);
        return (i == 0) ? RP0 : RP1;
    endfunction

    task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc          = 0;
        m_ready      = 1'b0;
        m_shadow     = '0;
        m_last_store = -1;
        m_last_s1    = NEVER;
        m_drop       = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_valid[i]      = 1'b0;
            m_data[i]       = '0;
            m_last_hs[i]    = NEVER;
            m_last_latch[i] = -2;
        end
    endtask

    // Compare the current cycle's outputs, advance the model, step one clock
    task automatic tick();
        bit a0, a1, hold_on, st0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("s0_ready%0d", i), W'(s0_ready[i]), W'(m_ready));
            chk($sformatf("s1_ready%0d", i), W'(s1_ready[i]), W'(m_ready));
            chk($sformatf("drv_valid%0d", i), W'(drv_valid[i]), W'(m_valid[i]));
            if (m_valid[i]) chk($sformatf("drv_data%0d", i), drv_data[i], m_data[i]);
            chk($sformatf("drop%0d", i), W'(drop[i]), W'(m_drop));
            if (cyc >= m_last_s1 + 1 && cyc <= m_last_s1 + HOLD - 1)
                chk($sformatf("overlay%0d", i), W'(overlay_active[i]), W'(1));
            else if (cyc > m_last_s1 + HOLD + 1)
                chk($sformatf("overlay%0d", i), W'(overlay_active[i]), W'(0));
        end
        a1      = s1_valid && m_ready;
        a0      = s0_valid && m_ready;
        hold_on = (cyc <= m_last_s1 + HOLD);
        st0     = a0 && !a1 && !hold_on;
        m_drop  = a0 && !st0;
        for (int i = 0; i < 2; i++) begin
            if (m_valid[i]) begin
                if (drv_ready) begin
                    m_valid[i]   = 1'b0;
                    m_last_hs[i] = cyc;
                end
            end else if (cyc >= m_last_hs[i] + mi_of(i) &&
                         (m_last_store >= m_last_latch[i] ||
                          (rp_of(i) != 0 && cyc >= m_last_hs[i] + rp_of(i)))) begin
                m_valid[i]      = 1'b1;
                m_data[i]       = m_shadow;
                m_last_latch[i] = cyc;
            end
        end
        if (a1) begin
            m_shadow     = s1_data;
            m_last_s1    = cyc;
            m_last_store = cyc;
        end else if (st0) begin
            m_shadow     = s0_data;
            m_last_store = cyc;
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send_s0(logic [W-1:0] d);
        s0_valid = 1'b1;
        s0_data  = d;
        tick();
        s0_valid = 1'b0;
    endtask

    task automatic wait_issue0();
        int n = 0;
        while (!m_valid[0] && n < 200) begin
            tick();
            n++;
        end
        chk("wait_issue", W'(drv_valid[0]), W'(1));
    endtask

    task automatic do_reset();
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // Blank frame after reset, then periodic refresh on instance 0
        drv_ready = 1'b1;
        run(150);

        // Coalescing: two meter frames two cycles apart
        send_s0(32'h0000_00FF);
        tick();
        send_s0(32'h0000_0FFF);
        run(40);

        // Same-cycle meter and overlay; meter frames dropped during hold
        s0_valid = 1'b1; s0_data = 32'h1111_1111;
        s1_valid = 1'b1; s1_data = 32'hA5A5_A5A5;
        tick();
        s0_valid = 1'b0; s1_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            run(9);
            send_s0(32'hBEEF_0000 | W'(k));
        end
        run(30);
        send_s0(32'h1234_5678);
        run(30);

        // Driver stall while the shadow changes underneath
        drv_ready = 1'b0;
        send_s0(32'h0000_00A0);
        wait_issue0();
        run(5);
        send_s0(32'h0000_0005);
        run(100);
        drv_ready = 1'b1;
        run(40);

        // Burst of meter frames spaced 10 cycles, then silence
        for (int k = 0; k < 3; k++) begin
            send_s0(32'hC0DE_0000 + W'(k));
            run(9);
        end
        run(120);

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            s0_valid  = ($urandom_range(0, 15) == 0);
            s0_data   = $urandom;
            s1_valid  = ($urandom_range(0, 299) == 0);
            s1_data   = $urandom;
            drv_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;

        // Reset while a frame is being offered
        drv_ready = 1'b0;
        send_s0(32'h0F0F_0F0F);
        wait_issue0();
        do_reset();
        chk("rst_drv_data", drv_data[0], '0);
        drv_ready = 1'b1;
        run(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
